// File: rtl/cpu_step_ctrl_if.sv
// Board-facing signal bundle for the step controller: raw button/switch in,
// pipeline clock-enable, mode and cycle counter out.
interface cpu_step_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             btn_step;
  logic             run;
  logic             step_en;
  logic             run_mode;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output btn_step,
    output run,
    input  step_en,
    input  run_mode,
    input  cycle_count
  );

  modport slave (
    input  btn_step,
    input  run,
    output step_en,
    output run_mode,
    output cycle_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Execution controller: debounced single-step pulses or divided free-run
// pulses, driving the pipeline clock enable plus a wrap-around step counter.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned CNT_W           = 16
) (
  input logic            clk50M,
  input logic            reset,
  cpu_step_ctrl_if.slave bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RLAST = RW'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic             btn_m, btn_s;
  logic             run_m, run_s;
  state_t           state;
  logic [DW-1:0]    dcnt;
  logic [RW-1:0]    rdiv;
  logic             step_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_fire;
  logic             run_fire;

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      run_m <= 1'b0;
      run_s <= 1'b0;
    end else begin
      btn_m <= bus.btn_step;
      btn_s <= btn_m;
      run_m <= bus.run;
      run_s <= run_m;
    end
  end

  // A button pulse landing right after a final run pulse (run just dropped)
  // is swallowed so step_en can never be high on back-to-back cycles.
  always_comb begin
    btn_fire = 1'b0;
    run_fire = 1'b0;
    if (state == PRESS_WAIT && btn_s && dcnt == DLAST && !run_s && !step_q)
      btn_fire = 1'b1;
    if (run_s && rdiv == RLAST)
      run_fire = 1'b1;
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s)
            state <= IDLE;
          else if (dcnt == DLAST)
            state <= PRESSED;
          else
            dcnt <= dcnt + 1'b1;
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s)
            state <= PRESSED;
          else if (dcnt == DLAST)
            state <= IDLE;
          else
            dcnt <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      rdiv <= '0;
    end else if (!run_s) begin
      rdiv <= '0;
    end else if (rdiv == RLAST) begin
      rdiv <= '0;
    end else begin
      rdiv <= rdiv + 1'b1;
    end
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      step_q <= btn_fire | run_fire;
      if (step_q)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.step_en     = step_q;
  assign bus.run_mode    = run_s;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios with literal expectations plus
// randomized button/switch/reset traffic checked every cycle against a model.
module tb_cpu_step_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 5;
  localparam int unsigned W  = 4;

  logic clk50M = 1'b0;
  logic reset  = 1'b0;

  cpu_step_ctrl_if #(.CNT_W(W)) bus ();

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (RD),
    .CNT_W          (W)
  ) dut (
    .clk50M(clk50M),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk50M = ~clk50M;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a button level is accepted after D+1 consecutive
  // synchronized samples disagreeing with the accepted level; a rising
  // acceptance steps in manual mode. Run mode steps on every RD-th
  // consecutive synchronized run sample.
  logic         m_b1 = 0, m_b2 = 0, m_r1 = 0, m_r2 = 0;
  logic         acc = 0, m_step = 0, fire;
  int unsigned  dlen = 0, rlen = 0;
  logic [W-1:0] m_cnt = '0;
  int unsigned  edge_n = 0;

  always @(posedge clk50M or posedge reset) begin
    if (reset) begin
      m_b1 = 0; m_b2 = 0; m_r1 = 0; m_r2 = 0;
      acc = 0; dlen = 0; rlen = 0; m_step = 0; m_cnt = '0;
    end else begin
      edge_n++;
      fire = 1'b0;
      if (m_b2 != acc) begin
        dlen++;
        if (dlen == D + 1) begin
          acc  = m_b2;
          dlen = 0;
          fire = m_b2 && !m_r2 && !m_step;
        end
      end else begin
        dlen = 0;
      end
      if (m_r2) begin
        rlen++;
        if (rlen == RD) begin
          rlen = 0;
          fire = 1'b1;
        end
      end else begin
        rlen = 0;
      end
      m_cnt  = m_cnt + W'(m_step);
      m_step = fire;
      m_b2 = m_b1; m_b1 = bus.btn_step;
      m_r2 = m_r1; m_r1 = bus.run;
    end
    #1;
    chk("step_en", 32'(bus.step_en), 32'(m_step));
    chk("run_mode", 32'(bus.run_mode), 32'(m_r2));
    chk("cycle_count", 32'(bus.cycle_count), 32'(m_cnt));
  end

  int unsigned dut_pulses = 0, last_edge = 0, prev_edge = 0;
  always @(negedge clk50M) begin
    if (bus.step_en === 1'b1) begin
      dut_pulses++;
      prev_edge = last_edge;
      last_edge = edge_n;
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk50M);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  int unsigned base;
  int unsigned len;
  bit          found;

  initial begin
    bus.btn_step = 1'b0;
    bus.run      = 1'b0;
    #1 reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // clean press and hold
    base = dut_pulses;
    bus.btn_step = 1'b1;
    cyc(D + 2);
    chk("press_early", 32'(bus.step_en), 0);
    cyc(1);
    chk("press_pulse", 32'(bus.step_en), 1);
    cyc(1);
    chk("press_after", 32'(bus.step_en), 0);
    chk("press_count", 32'(bus.cycle_count), 1);
    cyc(20);
    chk("hold_no_repeat", dut_pulses - base, 1);
    bus.btn_step = 1'b0;
    cyc(2 * D + 6);

    // bouncing press, then bouncing release
    base = dut_pulses;
    for (int i = 0; i < 4; i++) begin
      bus.btn_step = (i % 2 == 0);
      cyc(1);
    end
    bus.btn_step = 1'b1;
    cyc(D + 2);
    chk("bounce_none", dut_pulses - base, 0);
    cyc(1);
    chk("bounce_pulse", 32'(bus.step_en), 1);
    cyc(1);
    chk("bounce_count", 32'(bus.cycle_count), 2);
    bus.btn_step = 1'b0; cyc(1);
    bus.btn_step = 1'b1; cyc(1);
    bus.btn_step = 1'b0;
    cyc(2 * D + 6);
    chk("release_bounce_none", dut_pulses - base, 1);

    // asynchronous reset mid-count
    reset = 1'b1;
    #1;
    chk("rst_count", 32'(bus.cycle_count), 0);
    chk("rst_step", 32'(bus.step_en), 0);
    chk("rst_mode", 32'(bus.run_mode), 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // run mode, wrap of the counter
    bus.run = 1'b1;
    cyc(6);
    chk("run_first_early", 32'(bus.step_en), 0);
    cyc(1);
    chk("run_first_pulse", 32'(bus.step_en), 1);
    cyc(75);
    chk("run_count_15", 32'(bus.cycle_count), 15);
    cyc(1);
    chk("run_count_wrap", 32'(bus.cycle_count), 0);
    chk("run_period", last_edge - prev_edge, RD);

    // button has no effect in run mode
    base = dut_pulses;
    bus.btn_step = 1'b1;
    cyc(20);
    bus.btn_step = 1'b0;
    cyc(20);
    chk("run_btn_pulses", dut_pulses - base, 8);

    // drop run with the divider at 3
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (bus.step_en === 1'b1) found = 1'b1;
    end
    chk("wait_run_pulse", 32'(found), 1);
    cyc(1);
    bus.run = 1'b0;
    base = dut_pulses;
    cyc(20);
    chk("drop_run_none", dut_pulses - base, 0);

    // re-raise run
    bus.run = 1'b1;
    cyc(6);
    chk("reraise_early", 32'(bus.step_en), 0);
    cyc(1);
    chk("reraise_pulse", 32'(bus.step_en), 1);
    bus.run = 1'b0;
    cyc(10);

    // reset during press debounce, button still held afterwards
    bus.btn_step = 1'b1;
    cyc(5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(D + 2);
    chk("rst_pw_early", 32'(bus.step_en), 0);
    cyc(1);
    chk("rst_pw_pulse", 32'(bus.step_en), 1);
    bus.btn_step = 1'b0;
    cyc(2 * D + 6);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      bus.btn_step = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * D + 3);
      cyc(len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
